// File: rtl/toy_fetch_ctrl.sv
// Fetch sequencer: issues sequential fetch-block PCs to the icache, reserves fetch-buffer
// space for every in-flight request, and flushes/drops stale responses on a redirect.
module toy_fetch_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned MUX_IN      = 2,
    parameter int unsigned MAX_OUTST   = 4,
    parameter int unsigned FETCH_BYTES = 4 * MUX_IN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   boot_pc,
    input  logic                    fe_stall,
    input  logic                    redirect_vld,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic                    ic_req_vld,
    input  logic                    ic_req_rdy,
    output logic [ADDR_WIDTH-1:0]   ic_req_pc,
    input  logic                    ic_rsp_vld,
    input  logic [$clog2(DEPTH):0]  fb_free,
    output logic                    fb_req_vld,
    input  logic                    fb_req_rdy,
    output logic                    fb_cancel_en
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ADDR_WIDTH'(FETCH_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] BLK_STEP = ADDR_WIDTH'(FETCH_BYTES);
    localparam logic [CNT_W-1:0]      OUTST_MAX = CNT_W'(MAX_OUTST);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic [CNT_W-1:0]      drop_q, drop_d;

    logic        req_hs;
    logic        slot_ok;
    logic        room_ok;
    logic [31:0] rsv_need;

    // Worst case every in-flight request (stale ones included) writes MUX_IN entries.
    assign rsv_need  = (32'(outst_q) + 32'd1) * 32'(MUX_IN);
    assign room_ok   = 32'(fb_free) >= rsv_need;
    assign slot_ok   = outst_q < OUTST_MAX;
    assign ic_req_pc = pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        outst_d      = outst_q;
        drop_d       = drop_q;
        ic_req_vld   = 1'b0;
        fb_cancel_en = 1'b0;
        fb_req_vld   = 1'b0;
        req_hs       = 1'b0;

        unique case (state_q)
            StIdle: begin
                pc_d    = boot_pc;
                state_d = StRun;
            end
            StRun: begin
                ic_req_vld = !fe_stall && !redirect_vld && slot_ok && room_ok;
                if (redirect_vld) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                fb_cancel_en = 1'b1;
                state_d      = redirect_vld ? StFlush : StRun;
            end
            default: state_d = StIdle;
        endcase

        req_hs     = ic_req_vld && ic_req_rdy;
        fb_req_vld = ic_rsp_vld && (drop_q == '0) && !redirect_vld && (state_q != StFlush);

        if (req_hs && !ic_rsp_vld) begin
            outst_d = outst_q + 1'b1;
        end else if (!req_hs && ic_rsp_vld) begin
            outst_d = outst_q - 1'b1;
        end

        if (req_hs) begin
            pc_d = (pc_q & ~BLK_MASK) + BLK_STEP;
        end

        if (ic_rsp_vld && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end

        // Everything still in flight after this cycle's response belongs to the old path.
        if (redirect_vld && (state_q != StIdle)) begin
            pc_d   = redirect_pc;
            drop_d = outst_q - CNT_W'(ic_rsp_vld);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    a_no_rsp_underflow: assert property (@(posedge clk) disable iff (rst)
        !(ic_rsp_vld && (outst_q == '0)));

    a_reservation_held: assert property (@(posedge clk) disable iff (rst)
        !(fb_req_vld && !fb_req_rdy));

    a_drop_within_outst: assert property (@(posedge clk) disable iff (rst)
        drop_q <= outst_q);

endmodule

// File: tb/tb_toy_fetch_ctrl.sv
// Randomised scoreboard bench for toy_fetch_ctrl: a queue-based model predicts request PCs,
// buffer writes and flush pulses per cycle; a monitor pops and compares what the DUT shows.
module tb_toy_fetch_ctrl;

    localparam int unsigned AW        = 32;
    localparam int unsigned DEPTH     = 32;
    localparam int unsigned MUX_IN    = 2;
    localparam int unsigned MAX_OUTST = 4;
    localparam int unsigned FB        = 4 * MUX_IN;
    localparam int          FREE_W    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     boot_pc = '0;
    logic              fe_stall = 1'b0;
    logic              redirect_vld = 1'b0;
    logic [AW-1:0]     redirect_pc = '0;
    logic              ic_req_vld;
    logic              ic_req_rdy = 1'b0;
    logic [AW-1:0]     ic_req_pc;
    logic              ic_rsp_vld = 1'b0;
    logic [FREE_W-1:0] fb_free = FREE_W'(DEPTH);
    logic              fb_req_vld;
    logic              fb_req_rdy = 1'b1;
    logic              fb_cancel_en;

    toy_fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .MUX_IN     (MUX_IN),
        .MAX_OUTST  (MAX_OUTST),
        .FETCH_BYTES(FB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .boot_pc     (boot_pc),
        .fe_stall    (fe_stall),
        .redirect_vld(redirect_vld),
        .redirect_pc (redirect_pc),
        .ic_req_vld  (ic_req_vld),
        .ic_req_rdy  (ic_req_rdy),
        .ic_req_pc   (ic_req_pc),
        .ic_rsp_vld  (ic_rsp_vld),
        .fb_free     (fb_free),
        .fb_req_vld  (fb_req_vld),
        .fb_req_rdy  (fb_req_rdy),
        .fb_cancel_en(fb_cancel_en)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int            cyc;
        logic [AW-1:0] pc;
    } req_exp_t;

    req_exp_t exp_req_q[$];
    int       exp_wr_q[$];
    int       exp_cancel_q[$];

    // Environment: icache in-flight count and buffer occupancy, updated by the monitor.
    int env_inflight = 0;
    int occ          = 0;
    bit drain_en     = 1'b1;

    // Reference model: next fetch PC, boot/flush flags, and a stale flag per in-flight request.
    logic [AW-1:0] m_pc       = '0;
    bit            m_booting  = 1'b1;
    bit            m_flushing = 1'b0;
    bit            m_stale[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name, input int at);
        vectors++;
        miscompares++;
        $display("FAIL %s: event at cycle %0d not matched (now cycle %0d)", name, at, cyc);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            env_inflight = 0;
            occ          = 0;
        end else begin
            if (ic_req_vld) begin
                if (exp_req_q.size() == 0) begin
                    flag("ic_req_vld_unexpected", cyc);
                end else begin
                    req_exp_t e;
                    e = exp_req_q.pop_front();
                    check("ic_req_cycle", 64'(cyc), 64'(e.cyc));
                    check("ic_req_pc", 64'(ic_req_pc), 64'(e.pc));
                end
            end
            while (exp_req_q.size() > 0 && exp_req_q[0].cyc <= cyc) begin
                flag("ic_req_vld_missing", exp_req_q[0].cyc);
                void'(exp_req_q.pop_front());
            end

            if (fb_req_vld) begin
                if (exp_wr_q.size() == 0) begin
                    flag("fb_req_vld_unexpected", cyc);
                end else begin
                    check("fb_req_cycle", 64'(cyc), 64'(exp_wr_q.pop_front()));
                end
                check("fb_write_had_room", 64'(fb_req_rdy), 64'd1);
            end
            while (exp_wr_q.size() > 0 && exp_wr_q[0] <= cyc) begin
                flag("fb_req_vld_missing", exp_wr_q[0]);
                void'(exp_wr_q.pop_front());
            end

            if (fb_cancel_en) begin
                if (exp_cancel_q.size() == 0) begin
                    flag("fb_cancel_unexpected", cyc);
                end else begin
                    check("fb_cancel_cycle", 64'(cyc), 64'(exp_cancel_q.pop_front()));
                end
            end
            while (exp_cancel_q.size() > 0 && exp_cancel_q[0] <= cyc) begin
                flag("fb_cancel_missing", exp_cancel_q[0]);
                void'(exp_cancel_q.pop_front());
            end

            if (ic_req_vld && ic_req_rdy) env_inflight++;
            if (ic_rsp_vld) env_inflight--;
            if (fb_cancel_en) begin
                occ = 0;
            end else begin
                if (fb_req_vld) occ += MUX_IN;
                if (drain_en && occ > 0) begin
                    int d;
                    d = $urandom_range(0, 2);
                    occ -= (d > occ) ? occ : d;
                end
            end
        end
    end

    // One clock of stimulus plus the model's prediction for that same cycle.
    task automatic step(input bit rdy, input bit stall, input bit redir, input logic [AW-1:0] rpc,
                        input int rsp_pct, input int force_free);
        bit rsp;
        bit exp_vld;
        bit s;
        int n;
        @(posedge clk);
        #1;
        cyc++;
        rst          = 1'b0;
        ic_req_rdy   = rdy;
        fe_stall     = stall;
        redirect_vld = redir;
        redirect_pc  = rpc;
        rsp          = (env_inflight > 0) && ($urandom_range(0, 99) < rsp_pct);
        ic_rsp_vld   = rsp;
        fb_free      = (force_free >= 0) ? FREE_W'(force_free) : FREE_W'(int'(DEPTH) - occ);
        fb_req_rdy   = (int'(DEPTH) - occ) >= int'(MUX_IN);

        if (m_booting) begin
            m_pc      = boot_pc;
            m_booting = 1'b0;
        end else begin
            n = m_stale.size();
            if (m_flushing) exp_cancel_q.push_back(cyc);
            exp_vld = !m_flushing && !stall && !redir && (n < int'(MAX_OUTST))
                      && (int'(fb_free) >= (n + 1) * int'(MUX_IN));
            if (exp_vld) exp_req_q.push_back('{cyc: cyc, pc: m_pc});
            if (rsp) begin
                if (n == 0) begin
                    flag("model_rsp_without_request", cyc);
                end else begin
                    s = m_stale.pop_front();
                    if (!s && !redir && !m_flushing) exp_wr_q.push_back(cyc);
                end
            end
            if (exp_vld && rdy) begin
                m_stale.push_back(1'b0);
                m_pc = (m_pc & ~AW'(FB - 1)) + AW'(FB);
            end
            if (redir) begin
                foreach (m_stale[i]) m_stale[i] = 1'b1;
                m_pc = rpc;
            end
            m_flushing = redir;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        ic_rsp_vld   = 1'b0;
        redirect_vld = 1'b0;
        ic_req_rdy   = 1'b0;
        fe_stall     = 1'b0;
        m_booting    = 1'b1;
        m_flushing   = 1'b0;
        m_pc         = '0;
        m_stale.delete();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("rst_ic_req_vld", 64'(ic_req_vld), 64'd0);
        check("rst_fb_req_vld", 64'(fb_req_vld), 64'd0);
        check("rst_fb_cancel_en", 64'(fb_cancel_en), 64'd0);
        check("rst_ic_req_pc", 64'(ic_req_pc), 64'd0);
    endtask

    // Let every in-flight response return and the buffer empty out.
    task automatic drain();
        int k;
        for (k = 0; k < 40 && (env_inflight > 0 || m_stale.size() > 0); k++) begin
            step(1'b1, 1'b1, 1'b0, '0, 100, -1);
        end
        if (k == 40) flag("drain_timeout", cyc);
        repeat (12) step(1'b1, 1'b1, 1'b0, '0, 0, -1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        boot_pc = 32'h1000;
        do_reset(2);

        // Boot: one IDLE cycle then four back-to-back requests, capped by MAX_OUTST.
        repeat (7) step(1'b1, 1'b0, 1'b0, '0, 0, -1);
        drain();

        // Credit: 5 free entries admit two requests, 6 admit a third.
        repeat (4) step(1'b1, 1'b0, 1'b0, '0, 0, 5);
        repeat (3) step(1'b1, 1'b0, 1'b0, '0, 0, 6);
        drain();

        // Misaligned redirect, then a third request, then redirect with a live response.
        step(1'b1, 1'b0, 1'b1, 32'h2004, 0, -1);
        repeat (4) step(1'b1, 1'b0, 1'b0, '0, 0, -1);
        step(1'b1, 1'b0, 1'b1, 32'h5000, 100, -1);
        step(1'b1, 1'b0, 1'b0, '0, 0, -1);
        step(1'b1, 1'b0, 1'b0, '0, 0, -1);
        drain();

        // Back-to-back redirects with traffic in flight.
        repeat (2) step(1'b1, 1'b0, 1'b0, '0, 0, -1);
        step(1'b1, 1'b0, 1'b1, 32'h3000, 100, -1);
        step(1'b1, 1'b0, 1'b1, 32'h4000, 100, -1);
        repeat (3) step(1'b1, 1'b0, 1'b0, '0, 50, -1);
        drain();

        // PC wrap, backpressure hold and stall hold.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 0, -1);
        step(1'b1, 1'b0, 1'b0, '0, 0, -1);
        step(1'b1, 1'b0, 1'b0, '0, 0, -1);
        repeat (2) step(1'b0, 1'b0, 1'b0, '0, 0, -1);
        repeat (3) step(1'b1, 1'b1, 1'b0, '0, 0, -1);
        step(1'b1, 1'b0, 1'b0, '0, 0, -1);
        drain();

        // Random traffic with a reset in the middle; a redirect during IDLE is ignored.
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) drain_en = ($urandom_range(0, 3) != 0);
            if (i == 1500) begin
                boot_pc = $urandom;
                do_reset(1);
                step(1'b1, 1'b0, 1'b1, $urandom, 0, -1);
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0, $urandom, 50, -1);
        end
        drain_en = 1'b1;
        drain();

        @(negedge clk);
        #1;
        foreach (exp_req_q[i]) flag("ic_req_left_over", exp_req_q[i].cyc);
        foreach (exp_wr_q[i]) flag("fb_req_left_over", exp_wr_q[i]);
        foreach (exp_cancel_q[i]) flag("fb_cancel_left_over", exp_cancel_q[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
